// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   state_t          : arbiter FSM encoding (IDLE / ACCESS / DONE)
//   SIZE_*           : data size codes carried on size0/size1 and ram_data_size
//   TIMEOUT_DEFAULT  : default abort limit, in ACCESS cycles
//   wait_cnt_width() : width of the ACCESS wait counter for a given limit
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    localparam int TIMEOUT_DEFAULT = 255;

    // The wait counter is never narrower than 8 bits, and grows when the
    // limit no longer fits.
    function automatic int wait_cnt_width(input int timeout);
        if (timeout > 255) begin
            return $clog2(timeout + 1);
        end else begin
            return 8;
        end
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-input winner selection for the memory arbiter.
//   req0, req1 : raw access requests (port 0 = file loader, port 1 = CPU)
//   last       : index of the port served most recently
//   boot       : when high only port 0 is eligible
//   valid      : at least one eligible request
//   winner     : index of the selected port (meaningful when valid)
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic boot,
    output logic valid,
    output logic winner
);

    logic elig1_s;

    assign elig1_s = req1 & ~boot;

    // Lone eligible requester wins; a tie goes to the port not served last.
    always_comb begin
        valid = req0 | elig1_s;
        if (req0 && elig1_s) begin
            winner = ~last;
        end else if (elig1_s) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port RAM arbiter: file loader (port 0) and CPU (port 1) share one RAM.
// One access at a time: IDLE picks a winner and latches its request into the
// ram_* registers, ACCESS holds them until ram_mem_done (or the wait limit),
// DONE is a single cycle with the strobes low before the next decision.
//   clk, rst                 : clock and synchronous active-high reset
//   boot                     : port 0 exclusive while high
//   req/addr/wdata/we/sizeX  : per-port request
//   gntX, doneX, err, rdataX : per-port grant, completion pulse, abort flag, read data
//   ram_*                    : registered RAM request, strobes and RAM response
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  size0,
    input  logic [1:0]  size1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data_in,
    output logic [1:0]  ram_data_size,
    output logic        ram_cs,
    output logic        ram_we,
    output logic        ram_oe,
    input  logic [31:0] ram_data_out,
    input  logic        ram_mem_done
);

    localparam int CNT_W = wait_cnt_width(TIMEOUT);

    state_t             state_r;
    state_t             next_state_s;
    logic               owner_r;
    logic               last_r;
    logic [CNT_W-1:0]   wait_cnt_r;

    logic               pick_valid_s;
    logic               pick_winner_s;
    logic [31:0]        sel_addr_s;
    logic [31:0]        sel_wdata_s;
    logic               sel_we_s;
    logic [1:0]         sel_size_s;
    logic               timeout_hit_s;
    logic               finish_s;

    logic               gnt0_s;
    logic               gnt1_s;
    logic               cs_s;
    logic               we_s;
    logic               oe_s;
    logic               done0_s;
    logic               done1_s;
    logic               err_s;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_r),
        .boot   (boot),
        .valid  (pick_valid_s),
        .winner (pick_winner_s)
    );

    // The counter holds completed ACCESS cycles, so the current cycle is the
    // TIMEOUT-th one when it equals TIMEOUT-1. ram_mem_done wins that edge.
    assign timeout_hit_s = (wait_cnt_r == CNT_W'(TIMEOUT - 1));
    assign finish_s      = ram_mem_done | timeout_hit_s;

    // Request fields of the selected port.
    always_comb begin
        if (pick_winner_s) begin
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
            sel_we_s    = we1;
            sel_size_s  = size1;
        end else begin
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
            sel_we_s    = we0;
            sel_size_s  = size0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    next_state_s = ST_ACCESS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (finish_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of the grant, strobe and pulse registers.
    always_comb begin
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        cs_s    = 1'b0;
        we_s    = 1'b0;
        oe_s    = 1'b0;
        done0_s = 1'b0;
        done1_s = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    gnt0_s = ~pick_winner_s;
                    gnt1_s = pick_winner_s;
                    cs_s   = 1'b1;
                    we_s   = sel_we_s;
                    oe_s   = ~sel_we_s;
                end else begin
                    cs_s   = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (finish_s) begin
                    done0_s = ~owner_r;
                    done1_s = owner_r;
                    err_s   = ~ram_mem_done;
                end else begin
                    gnt0_s  = ~owner_r;
                    gnt1_s  = owner_r;
                    cs_s    = 1'b1;
                    we_s    = ram_we;
                    oe_s    = ~ram_we;
                end
            end
            ST_DONE: begin
                cs_s = 1'b0;
            end
            default: begin
                cs_s = 1'b0;
            end
        endcase
    end

    // Output registers for grants, strobes and completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            ram_cs <= 1'b0;
            ram_we <= 1'b0;
            ram_oe <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            err    <= 1'b0;
        end else begin
            gnt0   <= gnt0_s;
            gnt1   <= gnt1_s;
            ram_cs <= cs_s;
            ram_we <= we_s;
            ram_oe <= oe_s;
            done0  <= done0_s;
            done1  <= done1_s;
            err    <= err_s;
        end
    end

    // Request latch, wait counter, owner/pointer tracking and read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r       <= 1'b0;
            last_r        <= 1'b1;
            wait_cnt_r    <= {CNT_W{1'b0}};
            ram_address   <= 32'h0000_0000;
            ram_data_in   <= 32'h0000_0000;
            ram_data_size <= SIZE_BYTE;
            rdata0        <= 32'h0000_0000;
            rdata1        <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        owner_r       <= pick_winner_s;
                        wait_cnt_r    <= {CNT_W{1'b0}};
                        ram_address   <= sel_addr_s;
                        ram_data_in   <= sel_wdata_s;
                        ram_data_size <= sel_size_s;
                    end
                end
                ST_ACCESS: begin
                    if (finish_s) begin
                        // Pointer moves on every completion, aborted or not.
                        last_r <= owner_r;
                        if (ram_mem_done && !ram_we) begin
                            if (owner_r) begin
                                rdata1 <= ram_data_out;
                            end else begin
                                rdata0 <= ram_data_out;
                            end
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Instance dut uses the default
// wait limit; instance dut_to uses TIMEOUT=4 and has its own done input.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst, boot, req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1, ram_data_out;
    logic [1:0]  size0, size1;
    logic        ram_mem_done, mem_done_t;

    logic        gnt0, gnt1, done0, done1, err, ram_cs, ram_we, ram_oe;
    logic [31:0] rdata0, rdata1, ram_address, ram_data_in;
    logic [1:0]  ram_data_size;

    logic        gnt0_t, gnt1_t, done0_t, done1_t, err_t, ram_cs_t, ram_we_t, ram_oe_t;
    logic [31:0] rdata0_t, rdata1_t, ram_address_t, ram_data_in_t;
    logic [1:0]  ram_data_size_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc;
    logic d0, d1, e, both, g1;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .boot(boot), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .size0(size0), .size1(size1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
        .rdata0(rdata0), .rdata1(rdata1), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_size(ram_data_size),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_data_out(ram_data_out), .ram_mem_done(ram_mem_done)
    );

    mem_arbiter #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .boot(boot), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .size0(size0), .size1(size1),
        .gnt0(gnt0_t), .gnt1(gnt1_t), .done0(done0_t), .done1(done1_t), .err(err_t),
        .rdata0(rdata0_t), .rdata1(rdata1_t), .ram_address(ram_address_t),
        .ram_data_in(ram_data_in_t), .ram_data_size(ram_data_size_t),
        .ram_cs(ram_cs_t), .ram_we(ram_we_t), .ram_oe(ram_oe_t),
        .ram_data_out(ram_data_out), .ram_mem_done(mem_done_t)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after the grant edge. Raises the selected done input
    // 'lat' cycles later (never when lat < 0) and runs until a done pulse.
    task automatic serve(input bit inst, input int lat, output int cs_cycles,
                         output logic od0, output logic od1, output logic oe,
                         output logic oboth, output logic og1);
        logic fin;
        fin = 1'b0;
        cs_cycles = 0; od0 = 1'b0; od1 = 1'b0; oe = 1'b0; oboth = 1'b0; og1 = 1'b0;
        for (int k = 0; k < 300 && !fin; k++) begin
            if (inst ? ram_cs_t : ram_cs) cs_cycles++;
            if (gnt0 && gnt1) oboth = 1'b1;
            if (gnt1) og1 = 1'b1;
            if (k == lat) begin
                if (inst) mem_done_t = 1'b1;
                else ram_mem_done = 1'b1;
            end
            tick();
            od0 = inst ? done0_t : done0;
            od1 = inst ? done1_t : done1;
            oe  = inst ? err_t : err;
            if (od0 || od1) fin = 1'b1;
        end
        ram_mem_done = 1'b0;
        mem_done_t   = 1'b0;
        check_eq("serve_bound", 32'(fin), 32'd1);
    endtask

    initial begin
        rst = 1'b1; boot = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        size0 = 2'b00; size1 = 2'b00; ram_data_out = 32'h0;
        ram_mem_done = 1'b0; mem_done_t = 1'b0;
        tick(); tick();

        // Reset state
        check_eq("rst_gnt0", 32'(gnt0), 32'd0);
        check_eq("rst_gnt1", 32'(gnt1), 32'd0);
        check_eq("rst_cs", 32'(ram_cs), 32'd0);
        check_eq("rst_oe", 32'(ram_oe), 32'd0);
        check_eq("rst_done0", 32'(done0), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_addr", ram_address, 32'h0);
        check_eq("rst_rdata1", rdata1, 32'h0);
        rst = 1'b0;
        tick();

        // Boot mode: loader write, CPU request held but never granted
        boot = 1'b1; req0 = 1'b1; we0 = 1'b1; addr0 = 32'h100; wdata0 = 32'hCAFEF00D;
        size0 = SIZE_WORD; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h300;
        check_eq("lat_cs_before", 32'(ram_cs), 32'd0);
        tick();
        check_eq("boot_gnt0", 32'(gnt0), 32'd1);
        check_eq("boot_gnt1", 32'(gnt1), 32'd0);
        check_eq("boot_cs", 32'(ram_cs), 32'd1);
        check_eq("boot_we", 32'(ram_we), 32'd1);
        check_eq("boot_oe", 32'(ram_oe), 32'd0);
        check_eq("boot_addr", ram_address, 32'h100);
        check_eq("boot_wdata", ram_data_in, 32'hCAFEF00D);
        check_eq("boot_size", 32'(ram_data_size), 32'd3);
        serve(1'b0, 3, cyc, d0, d1, e, both, g1);
        check_eq("boot_cs_cycles", cyc, 32'd4);
        check_eq("boot_done0", 32'(d0), 32'd1);
        check_eq("boot_done1", 32'(d1), 32'd0);
        check_eq("boot_err", 32'(e), 32'd0);
        check_eq("boot_cs_off", 32'(ram_cs), 32'd0);
        req0 = 1'b0;
        tick();
        check_eq("boot_done_pulse", 32'(done0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (gnt1) g1 = 1'b1;
        end
        check_eq("boot_gnt1_never", 32'(g1), 32'd0);

        // Round robin with both ports reading continuously
        rst = 1'b1; tick(); rst = 1'b0; boot = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h80;
        for (int i = 0; i < 4; i++) begin
            ram_data_out = 32'hA000_0000 + 32'(i);
            tick();
            check_eq("rr_gnt0", 32'(gnt0), 32'((i % 2) == 0));
            check_eq("rr_gnt1", 32'(gnt1), 32'((i % 2) == 1));
            serve(1'b0, 2, cyc, d0, d1, e, both, g1);
            check_eq("rr_done0", 32'(d0), 32'((i % 2) == 0));
            check_eq("rr_both", 32'(both), 32'd0);
            check_eq("rr_done_cs", 32'(ram_cs), 32'd0);
            if ((i % 2) == 0) check_eq("rr_rdata0", rdata0, 32'hA000_0000 + 32'(i));
            else check_eq("rr_rdata1", rdata1, 32'hA000_0000 + 32'(i));
            if (i == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            tick();
        end

        // CPU read returns data into rdata1 only
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h200; ram_data_out = 32'h12345678;
        tick();
        check_eq("rd1_gnt1", 32'(gnt1), 32'd1);
        check_eq("rd1_addr", ram_address, 32'h200);
        check_eq("rd1_oe", 32'(ram_oe), 32'd1);
        serve(1'b0, 2, cyc, d0, d1, e, both, g1);
        check_eq("rd1_done1", 32'(d1), 32'd1);
        check_eq("rd1_rdata1", rdata1, 32'h12345678);
        check_eq("rd1_rdata0", rdata0, 32'hA000_0002);
        req1 = 1'b0; ram_data_out = 32'hDEADBEEF;
        tick(); tick();
        check_eq("rd1_hold", rdata1, 32'h12345678);

        // CPU write with request dropped mid-access
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h204; wdata1 = 32'h55AA55AA; size1 = 2'b01;
        tick();
        check_eq("drop_gnt1", 32'(gnt1), 32'd1);
        check_eq("drop_we", 32'(ram_we), 32'd1);
        check_eq("drop_wdata", ram_data_in, 32'h55AA55AA);
        check_eq("drop_size", 32'(ram_data_size), 32'd1);
        req1 = 1'b0;
        serve(1'b0, 3, cyc, d0, d1, e, both, g1);
        check_eq("drop_done1", 32'(d1), 32'd1);
        check_eq("drop_err", 32'(e), 32'd0);
        check_eq("drop_rdata1", rdata1, 32'h12345678);
        tick(); tick();
        check_eq("drop_no_regrant", 32'(ram_cs), 32'd0);

        // Reset during the second ACCESS cycle
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        tick();
        check_eq("pre_gnt0", 32'(gnt0), 32'd1);
        serve(1'b0, 1, cyc, d0, d1, e, both, g1);
        check_eq("pre_rdata0", rdata0, 32'hDEADBEEF);
        req1 = 1'b1; we1 = 1'b0;
        tick(); tick();
        check_eq("pre_tie_gnt1", 32'(gnt1), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check_eq("mrst_gnt1", 32'(gnt1), 32'd0);
        check_eq("mrst_cs", 32'(ram_cs), 32'd0);
        check_eq("mrst_oe", 32'(ram_oe), 32'd0);
        check_eq("mrst_done1", 32'(done1), 32'd0);
        check_eq("mrst_addr", ram_address, 32'h0);
        check_eq("mrst_wdata", ram_data_in, 32'h0);
        check_eq("mrst_rdata0", rdata0, 32'h0);
        check_eq("mrst_rdata1", rdata1, 32'h0);
        rst = 1'b0;
        tick();
        check_eq("mrst_tie_gnt0", 32'(gnt0), 32'd1);
        check_eq("mrst_tie_gnt1", 32'(gnt1), 32'd0);
        check_eq("mrst_no_done", 32'(done0 | done1), 32'd0);
        serve(1'b0, 1, cyc, d0, d1, e, both, g1);
        check_eq("mrst_done0", 32'(d0), 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Timeout instance: abort after 4 ACCESS cycles
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h3C0; size0 = 2'b01; ram_data_out = 32'h77777777;
        tick();
        check_eq("to_gnt0", 32'(gnt0_t), 32'd1);
        check_eq("to_gnt1", 32'(gnt1_t), 32'd0);
        check_eq("to_addr", ram_address_t, 32'h3C0);
        check_eq("to_size", 32'(ram_data_size_t), 32'd1);
        check_eq("to_wdata", ram_data_in_t, 32'hCAFEF00D);
        check_eq("to_we", 32'(ram_we_t), 32'd0);
        check_eq("to_oe", 32'(ram_oe_t), 32'd1);
        req0 = 1'b0;
        serve(1'b1, -1, cyc, d0, d1, e, both, g1);
        check_eq("to_cs_cycles", cyc, 32'd4);
        check_eq("to_done0", 32'(d0), 32'd1);
        check_eq("to_done1", 32'(d1), 32'd0);
        check_eq("to_err", 32'(e), 32'd1);
        check_eq("to_rdata0", rdata0_t, 32'h0);
        tick();
        check_eq("to_idle_cs", 32'(ram_cs_t), 32'd0);
        check_eq("to_idle_err", 32'(err_t), 32'd0);
        check_eq("to_idle_done", 32'(done0_t), 32'd0);

        // Done on the same edge the limit is reached counts as success
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        serve(1'b1, 3, cyc, d0, d1, e, both, g1);
        check_eq("tb_cs_cycles", cyc, 32'd4);
        check_eq("tb_done0", 32'(d0), 32'd1);
        check_eq("tb_err", 32'(e), 32'd0);
        check_eq("tb_rdata0", rdata0_t, 32'h77777777);
        check_eq("tb_rdata1", rdata1_t, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
